fnv_hash_ctrl: RTL and testbench
================================

Name: fnv_hash_ctrl

Overview:
Sequencing controller for the FNV-1a 32-bit hash datapath. It accepts a byte stream from the I2C front end over a valid/ready handshake and XORs each byte into the running hash. Each byte's multiply by FNV_PRIME runs as a multi-cycle shift-add sequence, so no 32x32 multiplier is needed (area budget). It also provides hash re-initialisation, a completion pulse and a byte counter to the register/readout logic.

Parameters:
OFFSET_BASIS, 32'h811C9DC5, hash value after reset or init
CNT_W, 16, width of the byte counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
init  input  1  synchronous command: reload OFFSET_BASIS, clear the counter, abort any byte in progress
in_data  input  8  byte to hash
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a byte this cycle
busy  output  1  multiply sequence in progress
done  output  1  one-cycle pulse when a byte's hash update commits
hash_out  output  32  current hash register
byte_count  output  CNT_W  bytes committed since the last init or reset, saturating

Behaviour:
- Reset (rst_n low, async): state=IDLE, hash=OFFSET_BASIS, byte_count=0, done=0, busy=0, step=0, acc=0, x=0. in_ready is 1 once rst_n is high.
- FNV_PRIME = 16777619 = 2^24+2^8+2^7+2^4+2^1+2^0.
- The product x*FNV_PRIME mod 2^32 is the sum of six terms, in step order 0..5: x<<24, x<<8, x<<7, x<<4, x<<1, x<<0. All sums are 32-bit and wrap modulo 2^32.
- States:
  - IDLE: in_ready = !init. busy=0.
  - MUL: in_ready=0. busy=1.
- IDLE, in_valid && in_ready: the byte is accepted.
  - x <= hash ^ {24'h0, in_data}; acc <= 0; step <= 0; go to MUL.
- MUL, each cycle: acc <= acc + term[step]; step <= step+1.
- MUL, step==5: hash <= acc + term[5]; byte_count <= byte_count+1, held at all-ones; done <= 1 for one cycle; go to IDLE.
- Latency: byte accepted at edge N; hash_out updated and done high after edge N+6; in_ready high after edge N+6. Throughput is one byte per 7 cycles. A new byte can be accepted in the cycle done is high.
- hash_out changes only on reset, on init, or on the step-5 commit. It is never updated with partial products.
- init (any state), highest priority:
  - hash <= OFFSET_BASIS; byte_count <= 0; step <= 0; state <= IDLE; done <= 0.
  - In MUL the in-flight byte is discarded with no done pulse.
  - In IDLE, init and in_valid in the same cycle: the byte is not accepted (in_ready=0).
- in_valid in MUL is ignored. The source holds data until in_ready.
- in_data is sampled only on the accept edge. Later changes to in_data do not affect the result.
- Async reset mid-MUL: immediate return to reset values. The partial result is lost.
- byte_count saturates at 2^CNT_W-1 and does not wrap. The hash keeps updating.
- done is registered and never asserts in the same cycle as busy rising.

Test Plan:
- Reset, no bytes -> hash_out=32'h811C9DC5, byte_count=0, in_ready=1, busy=0, done=0.
- Single byte 8'h61 ("a") -> done exactly 6 edges after the accept edge; hash_out=32'hE40C292C; byte_count=1; in_ready=0 for those 6 cycles.
- Stream "foobar" (66 6F 6F 62 61 72), in_valid held high -> 6 done pulses, one byte per 7 cycles; final hash_out=32'hBF9CF968; byte_count=6.
- Byte 8'h61 accepted, then init asserted at step 3 -> no done pulse; hash_out=32'h811C9DC5, byte_count=0. Then send "a" -> 32'hE40C292C.
- init and in_valid (8'h61) in the same IDLE cycle -> byte not accepted, no busy, hash_out stays 32'h811C9DC5. in_valid held into the next cycle is accepted normally.
- With CNT_W=2, send 5 bytes -> byte_count reads 1,2,3,3,3. The hash matches the software FNV-1a model for all 5 bytes. Async rst_n pulse mid-MUL returns all outputs to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fnv_hash_ctrl.sv
// FNV-1a 32-bit hash sequencer: accepts one byte per handshake and multiplies by
// FNV_PRIME through a six-step shift-add sequence instead of a 32x32 multiplier.
module fnv_hash_ctrl #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      hash_out,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q, state_d;
    logic [31:0]      hash_q, hash_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      x_q, x_d;
    logic [2:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [31:0]      term;

    // FNV_PRIME = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0, one term per step
    always_comb begin
        unique case (step_q)
            3'd0:    term = x_q << 24;
            3'd1:    term = x_q << 8;
            3'd2:    term = x_q << 7;
            3'd3:    term = x_q << 4;
            3'd4:    term = x_q << 1;
            default: term = x_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hash_d   = hash_q;
        acc_d    = acc_q;
        x_d      = x_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        busy     = (state_q == StMul);
        in_ready = (state_q == StIdle) && !init;

        if (init) begin
            hash_d  = OFFSET_BASIS;
            cnt_d   = '0;
            step_d  = 3'd0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_d     = hash_q ^ {24'h0, in_data};
                        acc_d   = 32'h0;
                        step_d  = 3'd0;
                        state_d = StMul;
                    end
                end
                default: begin
                    acc_d  = acc_q + term;
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd5) begin
                        hash_d  = acc_q + term;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        done_d  = 1'b1;
                        step_d  = 3'd0;
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hash_q  <= OFFSET_BASIS;
            acc_q   <= 32'h0;
            x_q     <= 32'h0;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hash_q  <= hash_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done       = done_q;
    assign hash_out   = hash_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_fnv_hash_ctrl.sv
// Self-checking bench for fnv_hash_ctrl: known-answer vectors, abort/reset corner
// cases and random byte streams against a plain-arithmetic FNV-1a model.
module tb_fnv_hash_ctrl;

    localparam logic [31:0] OFFSET = 32'h811C9DC5;

    logic        clk = 1'b0;
    logic        rst_n, init, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, busy, done;
    logic [31:0] hash_out;
    logic [15:0] byte_count;
    logic        in_ready2, busy2, done2;
    logic [31:0] hash_out2;
    logic [1:0]  byte_count2;

    fnv_hash_ctrl #(.OFFSET_BASIS(OFFSET), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .hash_out(hash_out),
        .byte_count(byte_count)
    );

    fnv_hash_ctrl #(.OFFSET_BASIS(OFFSET), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .init(init), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .busy(busy2), .done(done2), .hash_out(hash_out2),
        .byte_count(byte_count2)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hash;
    int          m_cnt;

    typedef struct {
        int          len;
        logic [47:0] data;
        logic [31:0] exp_hash;
    } vec_t;
    vec_t vecs[3];

    function automatic logic [31:0] fnv_step(logic [31:0] h, logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'd16777619;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int c1, c2;
        c1 = (m_cnt > 65535) ? 65535 : m_cnt;
        c2 = (m_cnt > 3) ? 3 : m_cnt;
        check({tag, " hash"}, hash_out, m_hash);
        check({tag, " hash2"}, hash_out2, m_hash);
        check({tag, " count"}, {16'h0, byte_count}, c1);
        check({tag, " count2"}, {30'h0, byte_count2}, c2);
    endtask

    // Called and returns at a negedge.
    task automatic do_init();
        init = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        init = 1'b0;
        m_hash = OFFSET;
        m_cnt = 0;
    endtask

    // Called and returns at a negedge; keep leaves in_valid high for a back-to-back byte.
    task automatic send_byte(input logic [7:0] b, input bit keep, input string tag);
        int k, lat;
        bit ok;
        logic [31:0] h0;
        in_data = b;
        in_valid = 1'b1;
        k = 0;
        #1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            check({tag, " accept timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        h0 = hash_out;
        @(posedge clk);
        lat = 0;
        ok = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            in_data = 8'($urandom);
            if (!keep) in_valid = 1'($urandom);
            if (done) break;
            if (!busy || in_ready || hash_out !== h0) ok = 1'b0;
            @(posedge clk);
            lat++;
        end
        if (!keep) in_valid = 1'b0;
        m_hash = fnv_step(m_hash, b);
        m_cnt++;
        check({tag, " latency"}, lat, 32'd6);
        check({tag, " mul phase"}, {31'h0, ok}, 32'd1);
        check({tag, " status"}, {29'h0, busy, done, in_ready}, 32'd3);
        check({tag, " status2"}, {29'h0, busy2, done2, in_ready2}, 32'd3);
        check_model(tag);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0;
        init = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h0;
        m_hash = OFFSET;
        m_cnt = 0;

        vecs[0] = '{len: 1, data: 48'h61_0000000000, exp_hash: 32'hE40C292C};
        vecs[1] = '{len: 6, data: 48'h666F6F626172, exp_hash: 32'hBF9CF968};
        vecs[2] = '{len: 0, data: 48'h0, exp_hash: 32'h811C9DC5};

        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset status", {29'h0, busy, done, in_ready}, 32'd1);
        check_model("reset");

        // Known-answer strings, bytes streamed with in_valid held high
        @(negedge clk);
        for (int v = 0; v < 3; v++) begin
            do_init();
            for (int i = 0; i < vecs[v].len; i++)
                send_byte(vecs[v].data[47-8*i -: 8], i < vecs[v].len - 1, $sformatf("vec%0d.%0d", v, i));
            check($sformatf("vec%0d kat", v), hash_out, vecs[v].exp_hash);
            check($sformatf("vec%0d cnt", v), {16'h0, byte_count}, vecs[v].len);
        end

        // init at step 3 aborts the in-flight byte
        do_init();
        in_data = 8'h61;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            if (done || done2) saw = 1'b1;
            @(negedge clk);
        end
        check("abort no done", {31'h0, saw}, 32'd0);
        check("abort busy", {31'h0, busy}, 32'd0);
        m_hash = OFFSET;
        m_cnt = 0;
        check_model("abort");
        send_byte(8'h61, 1'b0, "after abort");
        check("after abort kat", hash_out, 32'hE40C292C);

        // init and in_valid together: byte refused, then accepted next cycle
        do_init();
        init = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h61;
        #1;
        check("init blocks ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        init = 1'b0;
        #1;
        check("init blocks busy", {31'h0, busy}, 32'd0);
        check("init blocks hash", hash_out, OFFSET);
        check("ready after init", {31'h0, in_ready}, 32'd1);
        send_byte(8'h61, 1'b0, "held");
        check("held kat", hash_out, 32'hE40C292C);

        // Asynchronous reset in the middle of a multiply
        in_data = 8'h33;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_hash = OFFSET;
        m_cnt = 0;
        check("async rst status", {30'h0, busy, done}, 32'd0);
        check_model("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst ready", {31'h0, in_ready}, 32'd1);

        // Random streams with occasional re-init and idle gaps
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = 1'($urandom);
            if (!keep && $urandom_range(0, 7) == 0) do_init();
            send_byte(8'($urandom), keep, $sformatf("rnd%0d", i));
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
